// File: rtl/diff_backprop_drain.sv
// rtl/diff_backprop_drain.sv - Accepts a registered diff/backprop bundle and serializes diff_to_all one lane per cycle.
module diff_backprop_drain #(
    parameter int size      = 3,
    parameter int data_size = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [31:0]                 w_layer_index,
    input  logic [31:0]                 w_row_index,
    input  logic                        backprop_cost,
    input  logic [size*data_size-1:0]   diff_to_all,
    input  logic [31:0]                 dense_type,
    input  logic                        is_update,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_layer_index,
    output logic [31:0]                 out_row_index,
    output logic [31:0]                 out_col_index,
    output logic [data_size-1:0]        out_diff,
    output logic                        out_backprop_cost,
    output logic [31:0]                 out_dense_type,
    output logic                        out_last,
    output logic [31:0]                 drop_count
);

    localparam int cw = (size > 1) ? $clog2(size) : 1;
    localparam logic [cw-1:0] last_col = cw'(size - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state;
    logic [cw-1:0]        col;
    logic [data_size-1:0] lanes [size];
    logic                 at_last;
    logic                 accept;

    assign at_last = (col == last_col);

    // The last lane being taken frees the block, so in_ready follows out_ready then.
    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                SEND:    in_ready = out_ready && at_last;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept        = in_valid && in_ready;
    assign out_col_index = {{(32-cw){1'b0}}, col};
    assign out_diff      = lanes[col];
    assign out_last      = out_valid && at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            col               <= '0;
            out_valid         <= 1'b0;
            out_layer_index   <= '0;
            out_row_index     <= '0;
            out_backprop_cost <= 1'b0;
            out_dense_type    <= '0;
            drop_count        <= '0;
            for (int i = 0; i < size; i++) lanes[i] <= '0;
        end else begin
            if (state == SEND && out_ready) begin
                if (!at_last) begin
                    col <= col + 1'b1;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            end
            if (accept) begin
                if (is_update) begin
                    state             <= SEND;
                    out_valid         <= 1'b1;
                    col               <= '0;
                    out_layer_index   <= w_layer_index;
                    out_row_index     <= w_row_index;
                    out_backprop_cost <= backprop_cost;
                    out_dense_type    <= dense_type;
                    for (int i = 0; i < size; i++)
                        lanes[i] <= diff_to_all[i*data_size +: data_size];
                end else begin
                    drop_count <= drop_count + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_diff_backprop_drain.sv
// tb/tb_diff_backprop_drain.sv - Directed self-checking bench for diff_backprop_drain.
module tb_diff_backprop_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] w_layer_index;
    logic [31:0] w_row_index;
    logic        backprop_cost;
    logic [47:0] diff_to_all;
    logic [31:0] dense_type;
    logic        is_update;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_layer_index;
    logic [31:0] out_row_index;
    logic [31:0] out_col_index;
    logic [15:0] out_diff;
    logic        out_backprop_cost;
    logic [31:0] out_dense_type;
    logic        out_last;
    logic [31:0] drop_count;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    diff_backprop_drain #(.size(3), .data_size(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .w_layer_index(w_layer_index), .w_row_index(w_row_index),
        .backprop_cost(backprop_cost), .diff_to_all(diff_to_all),
        .dense_type(dense_type), .is_update(is_update),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_layer_index(out_layer_index), .out_row_index(out_row_index),
        .out_col_index(out_col_index), .out_diff(out_diff),
        .out_backprop_cost(out_backprop_cost), .out_dense_type(out_dense_type),
        .out_last(out_last), .drop_count(drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2,
                         input logic [31:0] layer, input logic [31:0] row, input logic upd);
        in_valid      = 1'b1;
        diff_to_all   = {l2, l1, l0};
        w_layer_index = layer;
        w_row_index   = row;
        is_update     = upd;
    endtask

    task automatic chk_elem(input string tag, input logic [15:0] d, input logic [31:0] c,
                            input logic [31:0] layer, input logic [31:0] row, input logic last);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_diff"},  {16'd0, out_diff}, {16'd0, d});
        chk({tag, "_col"},   out_col_index, c);
        chk({tag, "_layer"}, out_layer_index, layer);
        chk({tag, "_row"},   out_row_index, row);
        chk({tag, "_last"},  {31'd0, out_last}, {31'd0, last});
    endtask

    initial begin
        logic [15:0] bb_diff  [6];
        logic [31:0] bb_layer [6];
        bb_diff  = '{16'd11, 16'd12, 16'd13, 16'd21, 16'd22, 16'd23};
        bb_layer = '{32'd7, 32'd7, 32'd7, 32'd8, 32'd8, 32'd8};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; is_update = 1'b0;
        diff_to_all = '0; w_layer_index = '0; w_row_index = '0;
        backprop_cost = 1'b0; dense_type = '0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        step(); step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_drop", drop_count, 32'd0);
        chk("rst_col", out_col_index, 32'd0);
        chk("rst_layer", out_layer_index, 32'd0);
        chk("rst_in_ready_hold", {31'd0, in_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single bundle
        offer(16'd1, 16'd2, 16'd3, 32'd2, 32'd5, 1'b1);
        step();
        in_valid = 1'b0;
        chk_elem("one_c1", 16'd1, 32'd0, 32'd2, 32'd5, 1'b0);
        chk("one_c1_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk_elem("one_c2", 16'd2, 32'd1, 32'd2, 32'd5, 1'b0);
        chk("one_c2_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk_elem("one_c3", 16'd3, 32'd2, 32'd2, 32'd5, 1'b1);
        chk("one_c3_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("one_idle", {31'd0, out_valid}, 32'd0);

        // Back-to-back
        offer(16'd11, 16'd12, 16'd13, 32'd7, 32'd1, 1'b1);
        step();
        offer(16'd21, 16'd22, 16'd23, 32'd8, 32'd1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk_elem($sformatf("b2b_%0d", k), bb_diff[k], k % 3, bb_layer[k], 32'd1, (k % 3) == 2);
            if (k == 3) in_valid = 1'b0;
            step();
        end
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);

        // Backpressure on lane 1
        offer(16'd31, 16'd32, 16'd33, 32'd3, 32'd4, 1'b1);
        backprop_cost = 1'b1; dense_type = 32'd9;
        step();
        in_valid = 1'b0; backprop_cost = 1'b0; dense_type = 32'd0;
        chk_elem("bp_l0", 16'd31, 32'd0, 32'd3, 32'd4, 1'b0);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_elem($sformatf("bp_hold%0d", k), 16'd32, 32'd1, 32'd3, 32'd4, 1'b0);
            chk($sformatf("bp_cost%0d", k), {31'd0, out_backprop_cost}, 32'd1);
            chk($sformatf("bp_dense%0d", k), out_dense_type, 32'd9);
            if (k < 3) step();
        end
        out_ready = 1'b1;
        step();
        chk_elem("bp_l2", 16'd33, 32'd2, 32'd3, 32'd4, 1'b1);
        step();
        chk("bp_idle", {31'd0, out_valid}, 32'd0);

        // Drops then an update
        offer(16'd99, 16'd99, 16'd99, 32'd6, 32'd6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("drop_nv%0d", k), {31'd0, out_valid}, 32'd0);
        end
        chk("drop_cnt3", drop_count, 32'd3);
        offer(16'd41, 16'd42, 16'd43, 32'd4, 32'd2, 1'b1);
        step();
        in_valid = 1'b0;
        chk_elem("drop_l0", 16'd41, 32'd0, 32'd4, 32'd2, 1'b0);
        step();
        chk_elem("drop_l1", 16'd42, 32'd1, 32'd4, 32'd2, 1'b0);
        step();
        chk_elem("drop_l2", 16'd43, 32'd2, 32'd4, 32'd2, 1'b1);

        // Drop while last lane is taken
        offer(16'd77, 16'd77, 16'd77, 32'd1, 32'd1, 1'b0);
        chk("dlast_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("dlast_nv", {31'd0, out_valid}, 32'd0);
        chk("dlast_cnt", drop_count, 32'd4);
        chk("dlast_idle_ready", {31'd0, in_ready}, 32'd1);

        // Reset during SEND
        offer(16'd51, 16'd52, 16'd53, 32'd5, 32'd3, 1'b1);
        step();
        in_valid = 1'b0;
        chk_elem("rmid_l0", 16'd51, 32'd0, 32'd5, 32'd3, 1'b0);
        reset = 1'b1;
        #1;
        chk("rmid_in_ready_rst", {31'd0, in_ready}, 32'd0);
        step();
        reset = 1'b0;
        chk("rmid_nv", {31'd0, out_valid}, 32'd0);
        chk("rmid_drop", drop_count, 32'd0);
        #1;
        chk("rmid_in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rmid_quiet%0d", k), {31'd0, out_valid}, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
